// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings for loads,
// stores and branches, plus the data-bus FSM state type.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GNT   = 2'd1,
        WAIT_RDATA = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane select / extension for loads.
// Purely combinational. Build option MISALIGN_TRAP_EN: when undefined,
// misaligned offsets are rounded down to the access size so the access
// proceeds on the aligned lane; when defined, the raw offset is used
// (the caller suppresses the access anyway).
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [1:0]  w_lane;
    logic [15:0] w_shift;

    // Misalignment detection and effective lane offset
    always_comb begin
        o_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
`ifdef MISALIGN_TRAP_EN
        w_lane = i_addr_lo;
`else
        case (i_funct3[1:0])
            2'b01:   w_lane = {i_addr_lo[1], 1'b0};
            2'b10:   w_lane = 2'b00;
            default: w_lane = i_addr_lo;
        endcase
`endif
    end

    // Store byte enables and replicated write data
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << w_lane;
                o_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << w_lane;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        w_shift = 16'(i_load_data >> {w_lane, 3'b000});
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_LBU:  o_load_data = {24'd0, w_shift[7:0]};
            F3_LH:   o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_LHU:  o_load_data = {16'd0, w_shift[15:0]};
            default: o_load_data = i_load_data;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: data-bus access FSM, branch resolution
// and the MEM/WB register. Build option MISALIGN_TRAP_EN: when defined,
// misaligned accesses are dropped and flagged in MEM/WB instead of being
// rounded down to the aligned address.
//
// state      | meaning
// IDLE       | no access outstanding; a new request is driven straight from EX/MEM
// WAIT_GNT   | request driven from latched copies until the bus grants it
// WAIT_RDATA | load granted, waiting for rvalid; request deasserted
module memory_stage
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] branch_addr_from_execution,
    input  logic [XLEN-1:0] result_from_execution,
    input  logic [XLEN-1:0] rs2_data_from_execution,
    input  logic            equal_from_execution,
    input  logic            greater_from_execution,
    input  logic            lesser_from_execution,
    input  logic [2:0]      funct3_from_execution,
    input  logic [4:0]      rd_from_execution,
    input  logic            write_reg_from_execution,
    input  logic            select_from_execution,
    input  logic            read_from_execution,
    input  logic            write_from_execution,
    input  logic            branch_from_execution,
    input  logic            u_branch_from_execution,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_from_memory,
    output logic            branch_taken_from_memory,
    output logic [XLEN-1:0] branch_addr_from_memory,
    output logic [XLEN-1:0] result_from_memory,
    output logic [4:0]      rd_from_memory,
    output logic            write_reg_from_memory,
    output logic            misaligned_from_memory
);

    mem_state_t      r_state;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_be;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;

    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;
    logic            r_write_reg;
    logic            r_misaligned;

    logic            w_idle;
    logic [2:0]      w_funct3;
    logic [1:0]      w_addr_lo;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;
    logic            w_misaligned;
    logic            w_trap;
    logic            w_mem_op;
    logic            w_req;
    logic            w_complete;
    logic            w_cond;
    logic [XLEN-1:0] w_wb_result;
    logic            w_unused;

    // The comparator supplies greater for completeness; BGE/BGEU use !lesser.
    assign w_unused = greater_from_execution;

    assign w_idle    = (r_state == IDLE);
    assign w_funct3  = w_idle ? funct3_from_execution : r_funct3;
    assign w_addr_lo = w_idle ? result_from_execution[1:0] : r_addr_lo;

    load_store_align u_align (
        .i_funct3     (w_funct3),
        .i_addr_lo    (w_addr_lo),
        .i_store_data (rs2_data_from_execution),
        .i_load_data  (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

`ifdef MISALIGN_TRAP_EN
    assign w_trap = (read_from_execution | write_from_execution) & w_misaligned;
`else
    assign w_trap = 1'b0;
`endif

    assign w_mem_op = (read_from_execution | write_from_execution) & ~w_trap;

    // Bus request and completion for the current state
    always_comb begin
        w_req      = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                w_req      = w_mem_op;
                w_complete = w_mem_op & write_from_execution & dmem_gnt;
            end
            WAIT_GNT: begin
                w_req      = 1'b1;
                w_complete = r_we & dmem_gnt;
            end
            WAIT_RDATA: begin
                w_complete = dmem_rvalid;
            end
            default: begin
                w_req      = 1'b0;
                w_complete = 1'b0;
            end
        endcase
    end

    assign stall_from_memory = w_mem_op & ~w_complete;

    assign dmem_req   = w_req;
    assign dmem_we    = w_idle ? write_from_execution : r_we;
    assign dmem_addr  = w_idle ? {result_from_execution[XLEN-1:2], 2'b00} : r_addr;
    assign dmem_be    = w_idle ? w_be : r_be;
    assign dmem_wdata = w_idle ? w_wdata : r_wdata;

    // Branch condition from the comparator flags
    always_comb begin
        case (funct3_from_execution)
            F3_BEQ:            w_cond = equal_from_execution;
            F3_BNE:            w_cond = ~equal_from_execution;
            F3_BLT, F3_BLTU:   w_cond = lesser_from_execution;
            F3_BGE, F3_BGEU:   w_cond = ~lesser_from_execution;
            default:           w_cond = 1'b0;
        endcase
    end

    assign branch_taken_from_memory = u_branch_from_execution |
                                      (branch_from_execution & w_cond);
    assign branch_addr_from_memory  = branch_addr_from_execution;

    // Bus FSM; request fields are latched when leaving IDLE so they stay
    // stable while waiting for grant and for the load extension later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_we      <= 1'b0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_addr    <= {result_from_execution[XLEN-1:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_we      <= write_from_execution;
                        r_funct3  <= funct3_from_execution;
                        r_addr_lo <= result_from_execution[1:0];
                        if (dmem_gnt)
                            r_state <= write_from_execution ? IDLE : WAIT_RDATA;
                        else
                            r_state <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (dmem_gnt)
                        r_state <= r_we ? IDLE : WAIT_RDATA;
                end
                WAIT_RDATA: begin
                    if (dmem_rvalid)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A trapped access reports its faulting address instead of load data
    assign w_wb_result = (select_from_execution && !w_trap) ? w_load_data
                                                            : result_from_execution;

    // MEM/WB register; a stalled cycle inserts a bubble and keeps the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result     <= '0;
            r_rd         <= '0;
            r_write_reg  <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (stall_from_memory) begin
            r_rd         <= '0;
            r_write_reg  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_result     <= w_wb_result;
            r_rd         <= rd_from_execution;
            r_write_reg  <= write_reg_from_execution & ~w_trap;
            r_misaligned <= w_trap;
        end
    end

    assign result_from_memory     = r_result;
    assign rd_from_memory         = r_rd;
    assign write_reg_from_memory  = r_write_reg;
    assign misaligned_from_memory = r_misaligned;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized
// loads, stores, ALU pass-through and branches against a behavioural model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] branch_addr_from_execution;
    logic [31:0] result_from_execution;
    logic [31:0] rs2_data_from_execution;
    logic        equal_from_execution;
    logic        greater_from_execution;
    logic        lesser_from_execution;
    logic [2:0]  funct3_from_execution;
    logic [4:0]  rd_from_execution;
    logic        write_reg_from_execution;
    logic        select_from_execution;
    logic        read_from_execution;
    logic        write_from_execution;
    logic        branch_from_execution;
    logic        u_branch_from_execution;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_from_memory;
    logic        branch_taken_from_memory;
    logic [31:0] branch_addr_from_memory;
    logic [31:0] result_from_memory;
    logic [4:0]  rd_from_memory;
    logic        write_reg_from_memory;
    logic        misaligned_from_memory;

    memory_stage #(.XLEN(32)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .branch_addr_from_execution (branch_addr_from_execution),
        .result_from_execution      (result_from_execution),
        .rs2_data_from_execution    (rs2_data_from_execution),
        .equal_from_execution       (equal_from_execution),
        .greater_from_execution     (greater_from_execution),
        .lesser_from_execution      (lesser_from_execution),
        .funct3_from_execution      (funct3_from_execution),
        .rd_from_execution          (rd_from_execution),
        .write_reg_from_execution   (write_reg_from_execution),
        .select_from_execution      (select_from_execution),
        .read_from_execution        (read_from_execution),
        .write_from_execution       (write_from_execution),
        .branch_from_execution      (branch_from_execution),
        .u_branch_from_execution    (u_branch_from_execution),
        .dmem_req                   (dmem_req),
        .dmem_we                    (dmem_we),
        .dmem_addr                  (dmem_addr),
        .dmem_be                    (dmem_be),
        .dmem_wdata                 (dmem_wdata),
        .dmem_gnt                   (dmem_gnt),
        .dmem_rvalid                (dmem_rvalid),
        .dmem_rdata                 (dmem_rdata),
        .stall_from_memory          (stall_from_memory),
        .branch_taken_from_memory   (branch_taken_from_memory),
        .branch_addr_from_memory    (branch_addr_from_memory),
        .result_from_memory         (result_from_memory),
        .rd_from_memory             (rd_from_memory),
        .write_reg_from_memory      (write_reg_from_memory),
        .misaligned_from_memory     (misaligned_from_memory)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_result = '0;   // model of the MEM/WB result register

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (int'(off) % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
`ifdef MISALIGN_TRAP_EN
        return off;
`else
        return 2'(int'(off) - int'(off) % acc_bytes(f3));
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        int          n;
        logic [31:0] v;
        logic [31:0] mask;
        n = acc_bytes(f3);
        if (n == 4) return d;
        v    = d >> (8 * int'(off));
        mask = (32'd1 << (8 * n)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && (((v >> (8 * n - 1)) & 32'd1) != 0)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        int n;
        n = acc_bytes(f3);
        return 4'(((1 << n) - 1) << int'(off));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = acc_bytes(f3);
        if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit model_taken(input logic b, input logic u, input logic [2:0] f3,
                                       input logic eq, input logic lt);
        bit cond;
        case (int'(f3))
            0:       cond = eq;
            1:       cond = !eq;
            4, 6:    cond = lt;
            5, 7:    cond = !lt;
            default: cond = 1'b0;
        endcase
        return u || (b && cond);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        branch_addr_from_execution = '0;
        result_from_execution      = '0;
        rs2_data_from_execution    = '0;
        equal_from_execution       = 1'b0;
        greater_from_execution     = 1'b0;
        lesser_from_execution      = 1'b0;
        funct3_from_execution      = '0;
        rd_from_execution          = '0;
        write_reg_from_execution   = 1'b0;
        select_from_execution      = 1'b0;
        read_from_execution        = 1'b0;
        write_from_execution       = 1'b0;
        branch_from_execution      = 1'b0;
        u_branch_from_execution    = 1'b0;
        dmem_gnt                   = 1'b0;
        dmem_rvalid                = 1'b0;
        dmem_rdata                 = '0;
    endtask

    // One load/store: grant arrives g cycles after issue, rvalid v cycles after grant+1.
    // Called and returns at posedge+1.
    task automatic do_mem(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input logic [4:0] rd, input int g, input int v);
        int          c;
        logic [1:0]  off;
        logic [31:0] exp;
        bit          trap;
        result_from_execution    = addr;
        rs2_data_from_execution  = rs2;
        funct3_from_execution    = f3;
        rd_from_execution        = rd;
        write_reg_from_execution = is_load;
        select_from_execution    = is_load;
        read_from_execution      = is_load;
        write_from_execution     = !is_load;
        branch_from_execution    = 1'b0;
        u_branch_from_execution  = 1'b0;
        off  = eff_off(f3, addr[1:0]);
`ifdef MISALIGN_TRAP_EN
        trap = is_misaligned(f3, addr[1:0]);
`else
        trap = 1'b0;
`endif
        if (trap) begin
            dmem_gnt = 1'b1;
            #1;
            check("trap_stall", stall_from_memory, 0);
            check("trap_req", dmem_req, 0);
            @(posedge clk); #1;
            dmem_gnt = 1'b0;
            check("trap_flag", misaligned_from_memory, 1);
            check("trap_wr", write_reg_from_memory, 0);
            check("trap_result", result_from_memory, addr);
            m_result = addr;
            set_idle();
            return;
        end
        c = is_load ? g + 1 + v : g;
        for (int k = 0; k <= c; k++) begin
            dmem_gnt    = (k == g);
            dmem_rvalid = is_load && (k == c);
            dmem_rdata  = (k == c) ? rdata : $urandom;
            #1;
            check("stall", stall_from_memory, (k < c));
            check("req", dmem_req, (k <= g));
            if (k <= g) begin
                check("addr", dmem_addr, {addr[31:2], 2'b00});
                check("we", dmem_we, !is_load);
                check("be", dmem_be, model_be(f3, off));
                if (!is_load) check("wdata", dmem_wdata, model_wdata(f3, rs2));
            end
            @(posedge clk); #1;
            if (k < c) begin
                check("bubble_wr", write_reg_from_memory, 0);
                check("bubble_rd", rd_from_memory, 0);
                check("bubble_result", result_from_memory, m_result);
            end else begin
                exp = is_load ? model_load(f3, off, rdata) : addr;
                check("wb_result", result_from_memory, exp);
                check("wb_wr", write_reg_from_memory, is_load);
                check("wb_rd", rd_from_memory, rd);
                check("wb_mis", misaligned_from_memory, 0);
                m_result = exp;
            end
        end
        set_idle();
    endtask

    task automatic do_alu(input logic [31:0] res, input logic [4:0] rd, input logic wr);
        result_from_execution    = res;
        rd_from_execution        = rd;
        write_reg_from_execution = wr;
        #1;
        check("alu_stall", stall_from_memory, 0);
        check("alu_req", dmem_req, 0);
        @(posedge clk); #1;
        check("alu_result", result_from_memory, res);
        check("alu_wr", write_reg_from_memory, wr);
        check("alu_rd", rd_from_memory, rd);
        m_result = res;
        set_idle();
    endtask

    task automatic do_branch(input logic b, input logic u, input logic [2:0] f3,
                             input logic eq, input logic gt, input logic lt,
                             input logic [31:0] tgt, input logic [31:0] res,
                             input logic [4:0] rd, input logic wr);
        branch_from_execution      = b;
        u_branch_from_execution    = u;
        funct3_from_execution      = f3;
        equal_from_execution       = eq;
        greater_from_execution     = gt;
        lesser_from_execution      = lt;
        branch_addr_from_execution = tgt;
        result_from_execution      = res;
        rd_from_execution          = rd;
        write_reg_from_execution   = wr;
        #1;
        check("br_taken", branch_taken_from_memory, model_taken(b, u, f3, eq, lt));
        check("br_addr", branch_addr_from_memory, tgt);
        check("br_stall", stall_from_memory, 0);
        @(posedge clk); #1;
        check("br_result", result_from_memory, res);
        check("br_wr", write_reg_from_memory, wr);
        m_result = res;
        set_idle();
    endtask

    logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_result", result_from_memory, 0);
        check("rst_wr", write_reg_from_memory, 0);
        check("rst_rd", rd_from_memory, 0);
        check("rst_mis", misaligned_from_memory, 0);
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall_from_memory, 0);

        // Directed cases
        do_mem(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 5'd3, 0, 0);
        do_mem(1'b1, 3'b000, 32'h0000_0202, 32'h0, 32'h0080_0000, 5'd7, 2, 0);
        do_mem(1'b1, 3'b101, 32'h0000_0002, 32'h0, 32'hBEEF_1234, 5'd9, 0, 1);
        do_mem(1'b1, 3'b010, 32'h0000_0106, 32'h0, 32'h1357_9BDF, 5'd4, 1, 0);
        do_mem(1'b0, 3'b001, 32'h0000_0033, 32'h1234_ABCD, 32'h0, 5'd0, 2, 0);
        do_branch(1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 32'h80, 32'h11, 5'd0, 1'b0);
        do_branch(1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 32'h80, 32'h22, 5'd0, 1'b0);
        do_branch(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h90, 32'h44, 5'd1, 1'b1);

        // Reset while a load waits for rvalid, then a stray rvalid
        result_from_execution    = 32'h40;
        funct3_from_execution    = 3'b010;
        rd_from_execution        = 5'd5;
        write_reg_from_execution = 1'b1;
        select_from_execution    = 1'b1;
        read_from_execution      = 1'b1;
        dmem_gnt                 = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("rdwait_stall", stall_from_memory, 1);
        check("rdwait_req", dmem_req, 0);
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2_req", dmem_req, 0);
        check("rst2_result", result_from_memory, 0);
        check("rst2_wr", write_reg_from_memory, 0);
        check("rst2_rd", rd_from_memory, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("stray_stall", stall_from_memory, 0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("stray_wr", write_reg_from_memory, 0);
        check("stray_result", result_from_memory, 0);
        m_result = '0;

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: do_mem(1'b1, load_f3[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                          5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
                1: do_mem(1'b0, 3'($urandom_range(0, 2)), $urandom, $urandom, 32'h0,
                          5'($urandom), $urandom_range(0, 3), 0);
                2: do_alu($urandom, 5'($urandom), 1'($urandom));
                default: do_branch(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                                   1'($urandom), 1'($urandom), $urandom, $urandom,
                                   5'($urandom), 1'($urandom));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
